steer_en_sm: RTL and testbench



---
 rtl/steer_en_sm_pkg.sv | 17 +
 rtl/steer_en_sm_if.sv | 36 +++
 rtl/steer_en_sm.sv | 71 +++++++
 tb/tb_steer_en_sm.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/steer_en_sm_pkg.sv
// Shared types for the steering-enable control FSM.
// Fixed 2-bit state encoding; 2'b11 is never entered by design.
package steer_en_sm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT     = 2'b01,
        STEER_EN = 2'b10
    } state_t;

    localparam logic [1:0] ST_UNUSED = 2'b11;

    function automatic logic is_steer(input state_t s);
        return s == STEER_EN;
    endfunction

endpackage

// File: rtl/steer_en_sm_if.sv
// Rider-detection flags in, timer clear / steer enable / rider-off out.
// master drives the comparator flags; slave is the FSM.
interface steer_en_sm_if;

    logic tmr_full;
    logic sum_gt_min;
    logic sum_lt_min;
    logic diff_gt_1_4;
    logic diff_gt_15_16;
    logic clr_tmr;
    logic en_steer;
    logic rider_off;

    modport master (
        output tmr_full,
        output sum_gt_min,
        output sum_lt_min,
        output diff_gt_1_4,
        output diff_gt_15_16,
        input  clr_tmr,
        input  en_steer,
        input  rider_off
    );

    modport slave (
        input  tmr_full,
        input  sum_gt_min,
        input  sum_lt_min,
        input  diff_gt_1_4,
        input  diff_gt_15_16,
        output clr_tmr,
        output en_steer,
        output rider_off
    );

endinterface

// File: rtl/steer_en_sm.sv
// Steering-enable FSM: arms on rider weight, waits for a balanced 1.3 s
// settle, then enables steering until the rider steps or falls off.
module steer_en_sm
    import steer_en_sm_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    steer_en_sm_if.slave bus
);

    state_t state;
    state_t state_d;
    logic   en_steer_q;
    logic   en_steer_d;
    logic   clr_tmr_d;
    logic   rider_off_d;

    always_comb begin
        state_d     = state;
        clr_tmr_d   = 1'b0;
        rider_off_d = 1'b0;
        case (state)
            IDLE: begin
                if (bus.sum_gt_min) begin
                    state_d   = WAIT;
                    clr_tmr_d = 1'b1;
                end
            end
            WAIT: begin
                if (bus.sum_lt_min) begin
                    state_d     = IDLE;
                    rider_off_d = 1'b1;
                end else if (bus.diff_gt_1_4) begin
                    clr_tmr_d = 1'b1;
                end else if (bus.tmr_full) begin
                    state_d = STEER_EN;
                end
            end
            STEER_EN: begin
                if (bus.sum_lt_min) begin
                    state_d     = IDLE;
                    rider_off_d = 1'b1;
                end else if (bus.diff_gt_15_16) begin
                    state_d   = WAIT;
                    clr_tmr_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered from next state so it tracks STEER_EN exactly.
    assign en_steer_d = is_steer(state_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            en_steer_q <= 1'b0;
        end else begin
            state      <= state_d;
            en_steer_q <= en_steer_d;
        end
    end

    assign bus.clr_tmr   = clr_tmr_d;
    assign bus.rider_off = rider_off_d;
    assign bus.en_steer  = en_steer_q;

endmodule

// File: tb/tb_steer_en_sm.sv
// Directed bench for steer_en_sm with hand-computed expectations.
module tb_steer_en_sm;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    steer_en_sm_if bus_if ();

    steer_en_sm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] got,
                       input logic [1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic gt, input logic lt, input logic d14,
                         input logic d1516, input logic tf);
        bus_if.sum_gt_min    = gt;
        bus_if.sum_lt_min    = lt;
        bus_if.diff_gt_1_4   = d14;
        bus_if.diff_gt_15_16 = d1516;
        bus_if.tmr_full      = tf;
        #1;
    endtask

    task automatic outs(input string tag, input logic c, input logic e,
                        input logic o);
        chk({tag, ".clr"}, {1'b0, bus_if.clr_tmr}, {1'b0, c});
        chk({tag, ".en"}, {1'b0, bus_if.en_steer}, {1'b0, e});
        chk({tag, ".off"}, {1'b0, bus_if.rider_off}, {1'b0, o});
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(0, 1, 0, 0, 0);
        chk("rst_state", dut.state, 2'b00);
        outs("rst", 0, 0, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("idle_state", dut.state, 2'b00);
            outs("idle", 0, 0, 0);
        end

        // Arm into WAIT with an unbalanced rider
        drive(1, 0, 1, 0, 0);
        outs("arm", 1, 0, 0);
        tick();
        chk("arm_state", dut.state, 2'b01);
        for (int i = 0; i < 3; i++) begin
            outs("wait_unbal", 1, 0, 0);
            tick();
            chk("wait_unbal_st", dut.state, 2'b01);
        end

        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            outs("settle", 0, 0, 0);
            tick();
            chk("settle_st", dut.state, 2'b01);
        end
        drive(1, 0, 0, 0, 1);
        outs("tmr_full", 0, 0, 0);
        tick();
        chk("steer_st", dut.state, 2'b10);
        outs("steer", 0, 1, 0);
        drive(1, 0, 1, 0, 1);
        for (int i = 0; i < 2; i++) begin
            outs("steer_d14", 0, 1, 0);
            tick();
            chk("steer_d14_st", dut.state, 2'b10);
        end

        // Step-off back to WAIT, then rider leaves
        drive(1, 0, 1, 1, 0);
        outs("stepoff", 1, 1, 0);
        tick();
        chk("stepoff_st", dut.state, 2'b01);
        outs("stepoff_wait", 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        tick();
        chk("still_wait", dut.state, 2'b01);
        drive(0, 1, 0, 0, 0);
        outs("wait_off", 0, 0, 1);
        tick();
        chk("wait_off_st", dut.state, 2'b00);
        outs("idle_lt", 0, 0, 0);

        // Back to STEER_EN, then direct exit with both sum flags set
        drive(1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1);
        tick();
        chk("re_steer", dut.state, 2'b10);
        drive(1, 1, 0, 1, 0);
        outs("direct_off", 0, 1, 1);
        tick();
        chk("direct_st", dut.state, 2'b00);
        outs("after_off", 1, 0, 0);
        tick();
        chk("both_idle_st", dut.state, 2'b01);

        // Async reset in the middle of STEER_EN
        drive(0, 0, 0, 0, 1);
        tick();
        chk("pre_rst_st", dut.state, 2'b10);
        chk("pre_rst_en", {1'b0, bus_if.en_steer}, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        chk("async_st", dut.state, 2'b00);
        chk("async_en", {1'b0, bus_if.en_steer}, 2'b00);
        tick();
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
